wbit_regfile_2w2r: RTL and testbench

Parametrised multi-port register file for the basic CPU datapath. It is the next generation of the W-bit, 4-entry, 1-write/2-read register file.
- Generalised to 2^AW entries, with two write ports and two read ports.
- Adds same-cycle write-to-read bypass, a synchronous clear, per-entry dirty tracking and a write-collision flag.
- Sits between the ALU/load result buses (writes) and the operand fetch stage (reads).

---
 rtl/regf_pkg.sv | 32 +++
 rtl/regf_rdport.sv | 44 ++++
 rtl/wbit_regfile_2w2r.sv | 130 +++++++++++++
 tb/tb_wbit_regfile_2w2r.sv | 257 +++++++++++++++++++++++++
 4 files changed

// File: rtl/regf_pkg.sv
// Shared constants and write-port arbitration helper for the 2-write/2-read register file.
package regf_pkg;

    localparam int unsigned W_DEF       = 4;
    localparam int unsigned AW_DEF      = 2;
    localparam int unsigned D_DEF       = 1 << AW_DEF;
    localparam int unsigned RST_VAL_DEF = 0;

    // When both write ports target the same entry, port 1 takes the entry.
    localparam bit PORT1_WINS = 1'b1;

    typedef enum logic [1:0] {
        SEL_HOLD = 2'd0,
        SEL_P0   = 2'd1,
        SEL_P1   = 2'd2
    } wr_sel_e;

    // Resolve which write port owns an entry (or a read-port bypass) this cycle.
    function automatic wr_sel_e wr_sel(input logic hit0, input logic hit1);
        wr_sel_e sel;
        sel = SEL_HOLD;
        if (hit0 && hit1) begin
            sel = PORT1_WINS ? SEL_P1 : SEL_P0;
        end else if (hit1) begin
            sel = SEL_P1;
        end else if (hit0) begin
            sel = SEL_P0;
        end
        return sel;
    endfunction

endpackage

// File: rtl/regf_rdport.sv
// One combinational read port: stored-entry read with same-cycle write bypass.
// With REGF_ZERO_REG_EN defined, address 0 always reads as zero.
module regf_rdport
    import regf_pkg::*;
#(
    parameter int unsigned W  = W_DEF,
    parameter int unsigned AW = AW_DEF
) (
    input  logic [AW-1:0] addr,
    input  logic [W-1:0]  stored,
    input  logic          byp_en,
    input  logic          wen0,
    input  logic [AW-1:0] waddr0,
    input  logic [W-1:0]  wdata0,
    input  logic          wen1,
    input  logic [AW-1:0] waddr1,
    input  logic [W-1:0]  wdata1,
    output logic [W-1:0]  data_c
);

    logic hit0;
    logic hit1;

    assign hit0 = wen0 && (waddr0 == addr);
    assign hit1 = wen1 && (waddr1 == addr);

    // Bypass uses the same arbitration as the array write, so it predicts the next stored value.
    always_comb begin
        data_c = stored;
        if (byp_en) begin
            case (wr_sel(hit0, hit1))
                SEL_P1:  data_c = wdata1;
                SEL_P0:  data_c = wdata0;
                default: data_c = stored;
            endcase
        end
`ifdef REGF_ZERO_REG_EN
        if (addr == '0) begin
            data_c = '0;
        end
`endif
    end

endmodule

// File: rtl/wbit_regfile_2w2r.sv
// 2^AW-entry register file, two write ports, two bypassed read ports, dirty bits and collision flag.
// Optional REGF_ZERO_REG_EN hard-wires entry 0 to zero.
module wbit_regfile_2w2r
    import regf_pkg::*;
#(
    parameter int unsigned   W       = W_DEF,
    parameter int unsigned   AW      = AW_DEF,
    parameter logic [W-1:0]  RST_VAL = W'(RST_VAL_DEF)
) (
    input  logic                  CLK,
    input  logic                  RES,
    input  logic                  CLR,
    input  logic                  WEN0,
    input  logic [AW-1:0]         Add2,
    input  logic [W-1:0]          InA,
    input  logic                  WEN1,
    input  logic [AW-1:0]         Add3,
    input  logic [W-1:0]          InB,
    input  logic [AW-1:0]         Add0,
    input  logic [AW-1:0]         Add1,
    output logic [W-1:0]          Out0,
    output logic [W-1:0]          Out1,
    output logic [(1<<AW)-1:0]    Dirty,
    output logic                  Collide
);

    localparam int unsigned D = 1 << AW;

`ifdef REGF_ZERO_REG_EN
    localparam bit ZERO_REG = 1'b1;
`else
    localparam bit ZERO_REG = 1'b0;
`endif

    logic [D-1:0][W-1:0] ent;
    logic [D-1:0]        dirty_set;
    logic                collide_nxt;
    logic                byp_en;

    // Bypass is off during reset and clear so reads show the stored (reset) value.
    assign byp_en = RES && !CLR;

    for (genvar i = 0; i < D; i++) begin : g_ent
        if (ZERO_REG && (i == 0)) begin : g_zero
            assign ent[i] = '0;
        end else begin : g_reg
            logic         hit0;
            logic         hit1;
            logic [W-1:0] q;

            assign hit0   = WEN0 && (Add2 == AW'(i));
            assign hit1   = WEN1 && (Add3 == AW'(i));
            assign ent[i] = q;

            always_ff @(posedge CLK or negedge RES) begin
                if (!RES) begin
                    q <= RST_VAL;
                end else if (CLR) begin
                    q <= RST_VAL;
                end else begin
                    case (wr_sel(hit0, hit1))
                        SEL_P1:  q <= InB;
                        SEL_P0:  q <= InA;
                        default: q <= q;
                    endcase
                end
            end
        end
    end

    always_comb begin
        dirty_set = '0;
        if (WEN0) begin
            dirty_set[Add2] = 1'b1;
        end
        if (WEN1) begin
            dirty_set[Add3] = 1'b1;
        end
        if (ZERO_REG) begin
            dirty_set[0] = 1'b0;
        end
    end

    always_comb begin
        collide_nxt = WEN0 && WEN1 && (Add2 == Add3);
        if (ZERO_REG && (Add2 == '0)) begin
            collide_nxt = 1'b0;
        end
    end

    always_ff @(posedge CLK or negedge RES) begin
        if (!RES) begin
            Dirty   <= '0;
            Collide <= 1'b0;
        end else if (CLR) begin
            Dirty   <= '0;
            Collide <= 1'b0;
        end else begin
            Dirty   <= Dirty | dirty_set;
            Collide <= collide_nxt;
        end
    end

    regf_rdport #(.W(W), .AW(AW)) u_rd0 (
        .addr   (Add0),
        .stored (ent[Add0]),
        .byp_en (byp_en),
        .wen0   (WEN0),
        .waddr0 (Add2),
        .wdata0 (InA),
        .wen1   (WEN1),
        .waddr1 (Add3),
        .wdata1 (InB),
        .data_c (Out0)
    );

    regf_rdport #(.W(W), .AW(AW)) u_rd1 (
        .addr   (Add1),
        .stored (ent[Add1]),
        .byp_en (byp_en),
        .wen0   (WEN0),
        .waddr0 (Add2),
        .wdata0 (InA),
        .wen1   (WEN1),
        .waddr1 (Add3),
        .wdata1 (InB),
        .data_c (Out1)
    );

endmodule

// File: tb/tb_wbit_regfile_2w2r.sv
// Self-checking bench for wbit_regfile_2w2r: directed plan steps plus randomized traffic
// against an array-based reference model.
module tb_wbit_regfile_2w2r;

    localparam int unsigned W  = 4;
    localparam int unsigned AW = 2;
    localparam int unsigned D  = 1 << AW;

    logic          CLK;
    logic          RES;
    logic          CLR;
    logic          WEN0;
    logic [AW-1:0] Add2;
    logic [W-1:0]  InA;
    logic          WEN1;
    logic [AW-1:0] Add3;
    logic [W-1:0]  InB;
    logic [AW-1:0] Add0;
    logic [AW-1:0] Add1;
    logic [W-1:0]  Out0;
    logic [W-1:0]  Out1;
    logic [D-1:0]  Dirty;
    logic          Collide;

    int checks   = 0;
    int failures = 0;

    logic [W-1:0] m_mem [D];
    logic [D-1:0] m_dirty;
    logic         m_col;

    wbit_regfile_2w2r dut (
        .CLK     (CLK),
        .RES     (RES),
        .CLR     (CLR),
        .WEN0    (WEN0),
        .Add2    (Add2),
        .InA     (InA),
        .WEN1    (WEN1),
        .Add3    (Add3),
        .InB     (InB),
        .Add0    (Add0),
        .Add1    (Add1),
        .Out0    (Out0),
        .Out1    (Out1),
        .Dirty   (Dirty),
        .Collide (Collide)
    );

    initial CLK = 1'b0;
    always #5 CLK = ~CLK;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic model_reset();
        for (int i = 0; i < D; i++) m_mem[i] = '0;
        m_dirty = '0;
        m_col   = 1'b0;
    endtask

    // Expected read value straight from the behavioural rules.
    function automatic logic [W-1:0] exp_out(input logic [AW-1:0] a);
`ifdef REGF_ZERO_REG_EN
        if (a == '0) return '0;
`endif
        if (RES !== 1'b1) return '0;
        if (CLR) return m_mem[a];
        if (WEN1 && Add3 == a) return InB;
        if (WEN0 && Add2 == a) return InA;
        return m_mem[a];
    endfunction

    task automatic check_all(input string tag);
        chk({tag, "_out0"},    32'(Out0),    32'(exp_out(Add0)));
        chk({tag, "_out1"},    32'(Out1),    32'(exp_out(Add1)));
        chk({tag, "_dirty"},   32'(Dirty),   32'(m_dirty));
        chk({tag, "_collide"}, 32'(Collide), 32'(m_col));
    endtask

    // Advance one clock edge, updating the model from the inputs seen at that edge.
    task automatic tick();
        logic [W-1:0] nmem [D];
        logic [D-1:0] ndirty;
        logic         ncol;
        for (int i = 0; i < D; i++) nmem[i] = m_mem[i];
        ndirty = m_dirty;
        ncol   = m_col;
        if (RES === 1'b1) begin
            if (CLR) begin
                for (int i = 0; i < D; i++) nmem[i] = '0;
                ndirty = '0;
                ncol   = 1'b0;
            end else begin
                if (WEN0) begin nmem[Add2] = InA; ndirty[Add2] = 1'b1; end
                if (WEN1) begin nmem[Add3] = InB; ndirty[Add3] = 1'b1; end
                ncol = WEN0 && WEN1 && (Add2 == Add3);
`ifdef REGF_ZERO_REG_EN
                nmem[0]   = '0;
                ndirty[0] = 1'b0;
                if (Add2 == '0) ncol = 1'b0;
`endif
            end
        end
        @(posedge CLK);
        #1;
        for (int i = 0; i < D; i++) m_mem[i] = nmem[i];
        m_dirty = ndirty;
        m_col   = ncol;
    endtask

    initial begin
        RES  = 1'b1;
        CLR  = 1'b0;
        WEN0 = 1'b0;
        WEN1 = 1'b0;
        Add0 = '0;
        Add1 = '0;
        Add2 = '0;
        Add3 = '0;
        InA  = '0;
        InB  = '0;
        model_reset();
        #2 RES = 1'b0;

        // Reset: every address reads zero, no dirty, no collision
        for (int a = 0; a < D; a++) begin
            Add0 = AW'(a);
            Add1 = AW'(D - 1 - a);
            #1;
            check_all("reset");
        end
        tick();
        RES = 1'b1;
        #1;
        check_all("reset_rel");

        // Basic write/read
        WEN0 = 1'b1; Add2 = 2'd0; InA = 4'b1100;
        tick();
        Add2 = 2'd1; InA = 4'b0011;
        tick();
        WEN0 = 1'b0; Add0 = 2'd0; Add1 = 2'd1;
        #1;
        check_all("basic");
`ifndef REGF_ZERO_REG_EN
        chk("basic_out0_const", 32'(Out0), 32'h0000_000C);
        chk("basic_dirty_const", 32'(Dirty), 32'h0000_0003);
`endif

        // Bypass before the edge, stored after
        Add1 = 2'd3; WEN1 = 1'b1; Add3 = 2'd3; InB = 4'b0001;
        #1;
        chk("bypass_pre", 32'(Out1), 32'h1);
        check_all("bypass_pre");
        tick();
        WEN1 = 1'b0;
        #1;
        chk("bypass_post", 32'(Out1), 32'h1);
        check_all("bypass_post");

        // Collision: port 1 wins, Collide for one cycle
        WEN0 = 1'b1; WEN1 = 1'b1; Add2 = 2'd2; Add3 = 2'd2;
        InA = 4'b1010; InB = 4'b0101; Add0 = 2'd2;
        #1;
        chk("collide_byp", 32'(Out0), 32'h5);
        check_all("collide_pre");
        tick();
        WEN0 = 1'b0; WEN1 = 1'b0;
        #1;
        chk("collide_entry", 32'(Out0), 32'h5);
        chk("collide_flag", 32'(Collide), 32'h1);
        check_all("collide_post");
        tick();
        #1;
        chk("collide_drop", 32'(Collide), 32'h0);
        check_all("collide_drop");

        // Clear overrides a simultaneous write
        CLR = 1'b1; WEN0 = 1'b1; Add2 = 2'd1; InA = 4'b1111; Add0 = 2'd1;
        #1;
        check_all("clr_pre");
        tick();
        CLR = 1'b0; WEN0 = 1'b0;
        for (int a = 0; a < D; a++) begin
            Add0 = AW'(a);
            Add1 = AW'(a);
            #1;
            chk("clr_entry", 32'(Out0), 32'h0);
            check_all("clr_post");
        end

        // Async reset between edges with a pending write
        WEN1 = 1'b1; Add3 = 2'd2; InB = 4'b1111; Add0 = 2'd2; Add1 = 2'd2;
        #1;
        check_all("async_pre");
        #1 RES = 1'b0;
        model_reset();
        #1;
        chk("async_out0", 32'(Out0), 32'h0);
        check_all("async_low");
        tick();
        check_all("async_edge");
        RES = 1'b1; WEN1 = 1'b0;
        #1;
        chk("async_nowrite", 32'(Out0), 32'h0);
        check_all("async_rel");

`ifdef REGF_ZERO_REG_EN
        WEN0 = 1'b1; Add2 = 2'd0; InA = 4'b1111; Add0 = 2'd0;
        #1;
        chk("zero_byp", 32'(Out0), 32'h0);
        tick();
        WEN0 = 1'b0;
        #1;
        chk("zero_read", 32'(Out0), 32'h0);
        chk("zero_dirty", 32'(Dirty[0]), 32'h0);
`endif

        // Randomized traffic, occasional clear and asynchronous reset
        for (int n = 0; n < 400; n++) begin
            WEN0 = 1'($urandom);
            WEN1 = 1'($urandom);
            Add2 = AW'($urandom_range(0, D - 1));
            Add3 = ($urandom_range(0, 3) == 0) ? Add2 : AW'($urandom_range(0, D - 1));
            InA  = W'($urandom);
            InB  = W'($urandom);
            Add0 = AW'($urandom_range(0, D - 1));
            Add1 = AW'($urandom_range(0, D - 1));
            CLR  = ($urandom_range(0, 11) == 0);
            #1;
            check_all("rnd");
            if ($urandom_range(0, 39) == 0) begin
                #1 RES = 1'b0;
                model_reset();
                #1;
                check_all("rnd_rst");
                tick();
                RES = 1'b1;
            end else begin
                tick();
            end
        end
        CLR = 1'b0; WEN0 = 1'b0; WEN1 = 1'b0;
        #1;
        check_all("rnd_end");

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
